rom_scan_ctrl: RTL and testbench
================================

ROM_SCAN_CTRL -- requirements
Module: rom_scan_ctrl

Interface
REQ-001 SHALL have parameter Width, default 32, ROM word width in bits.
REQ-002 SHALL have parameter Depth, default 2048, ROM words; scan covers 0..Depth-1.
REQ-003 SHALL have parameter Aw, default $clog2(Depth), ROM address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  single-cycle request to begin a full-ROM scan.
REQ-007 SHALL have port expected_i  input  Width  reference checksum, sampled when a scan completes.
REQ-008 SHALL have port host_req_i  input  1  host read request.
REQ-009 SHALL have port host_addr_i  input  Aw  host read address.
REQ-010 SHALL have port host_gnt_o  output  1  host request accepted this cycle.
REQ-011 SHALL have port host_rvalid_o  output  1  host read data valid.
REQ-012 SHALL have port host_rdata_o  output  Width  host read data.
REQ-013 SHALL have port rom_addr_o  output  Aw  ROM address.
REQ-014 SHALL have port rom_cs_o  output  1  ROM chip select; ROM returns data one cycle later.
REQ-015 SHALL have port rom_data_i  input  Width  ROM read data.
REQ-016 SHALL have port rom_dvalid_i  input  1  ROM data valid (registered cs).
REQ-017 SHALL have ports busy_o, done_o, pass_o (output, 1 each) and checksum_o (output, Width): scan in progress, completion pulse, checksum-match flag, running checksum.

Function
REQ-018 SHALL implement FSM IDLE -> SCAN -> DRAIN -> DONE -> (IDLE on next cycle); start_i is acted on only in IDLE.
REQ-019 SHALL, on start_i in IDLE, clear checksum_o to 0, clear pass_o, reset the issue and receive counters, and enter SCAN next cycle.
REQ-020 SHALL, in SCAN, assert rom_cs_o every cycle with rom_addr_o = 0,1,..,Depth-1 on consecutive cycles, entering DRAIN after issuing address Depth-1.
REQ-021 SHALL tag each issued cs as scan or host in a one-cycle owner register; rom_dvalid_i is routed by that tag only.
REQ-022 SHALL, on each scan-tagged rom_dvalid_i, update checksum_o <= {checksum_o[Width-2:0], checksum_o[Width-1]} ^ rom_data_i (rotate-left-1 then XOR), modulo Width bits.
REQ-023 SHALL count scan-tagged responses; in DRAIN, after the Depth-th response, go to DONE.
REQ-024 SHALL, in DONE, pulse done_o high for exactly one cycle and register pass_o = (checksum_o == expected_i); pass_o and checksum_o hold until the next start_i.
REQ-025 SHALL drive busy_o high in SCAN and DRAIN only.
REQ-026 SHALL grant host reads only in IDLE: host_gnt_o = host_req_i & ~start_i & (state==IDLE), combinational; granted cycle drives rom_cs_o=1, rom_addr_o=host_addr_i.
REQ-027 SHALL drive host_gnt_o low in SCAN, DRAIN, DONE; a held host_req_i is granted on first IDLE cycle.
REQ-028 SHALL drive host_rvalid_o = rom_dvalid_i & host-tag and host_rdata_o = rom_data_i (pass-through) when valid, else 0.
REQ-029 SHALL give start_i priority over host_req_i in the same IDLE cycle; a host read granted the previous cycle still completes (rvalid) in the first SCAN cycle.
REQ-030 SHALL ignore start_i outside IDLE; rom_cs_o=0 and rom_addr_o=0 when no access issued.
REQ-031 SHALL support back-to-back host reads, one per cycle, in IDLE.

Reset
REQ-032 SHALL, while rst_ni=0 (asynchronously), force state IDLE, counters and owner tag 0, and all outputs 0 (busy_o, done_o, pass_o, checksum_o, host_gnt_o, host_rvalid_o, host_rdata_o, rom_cs_o, rom_addr_o).
REQ-033 SHALL, on reset mid-scan, abandon the scan with no done_o pulse and ignore any rom_dvalid_i returned in the first cycle after reset release.

Verification (Width=32, Depth=4, ROM word k = k+1, 1-cycle ROM model)
REQ-034 SHALL pass: start_i at cycle 0, expected_i=2 -> rom_cs_o cycles 1-4 addr 0,1,2,3; checksum 1,0,3,2; done_o single pulse cycle 6; pass_o=1, checksum_o=2.
REQ-035 SHALL pass: same scan with expected_i=5 -> done_o pulse, pass_o=0, checksum_o=2.
REQ-036 SHALL pass: host_req_i held with addr 3 during scan -> host_gnt_o=0 until IDLE, then gnt, next cycle host_rvalid_o=1, host_rdata_o=4, checksum unchanged.
REQ-037 SHALL pass: start_i and host_req_i same IDLE cycle -> no gnt, scan starts; host read granted after DONE.
REQ-038 SHALL pass: rst_ni low at cycle 3 of scan -> all outputs 0 immediately; no done_o; subsequent start_i produces checksum_o=2, pass_o=1.
REQ-039 SHALL pass: start_i pulsed during SCAN -> ignored; exactly 4 rom_cs_o cycles and one done_o.

Source files
------------

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl
//   Walks a single-port ROM from address 0 to Depth-1, folding every word into
//   a rotate-left-1/XOR checksum, then compares the result with a reference
//   value. While no scan is running, the controller lends the ROM port to a
//   host so that it can make single-word reads.
//
// Ports
//   clk_i, rst_ni       clock; asynchronous active-low reset
//   start_i             one-cycle request to begin a full scan (IDLE only)
//   expected_i          reference checksum, sampled in the DONE cycle
//   host_req_i/addr_i   host read request and address
//   host_gnt_o          combinational grant (IDLE only; start_i wins)
//   host_rvalid_o/rdata host read data, one cycle after the grant
//   rom_addr_o/cs_o     ROM port; data returns one cycle after cs
//   rom_data_i/dvalid_i ROM read data and its valid strobe
//   busy_o              scan in progress (SCAN, DRAIN)
//   done_o              one-cycle completion pulse
//   pass_o              checksum matched expected_i (held until next start)
//   checksum_o          running / final checksum
module rom_scan_ctrl #(
  parameter int Width = 32,
  parameter int Depth = 2048,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [Width-1:0] expected_i,
  input  logic             host_req_i,
  input  logic [Aw-1:0]    host_addr_i,
  output logic             host_gnt_o,
  output logic             host_rvalid_o,
  output logic [Width-1:0] host_rdata_o,
  output logic [Aw-1:0]    rom_addr_o,
  output logic             rom_cs_o,
  input  logic [Width-1:0] rom_data_i,
  input  logic             rom_dvalid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [Width-1:0] checksum_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [Aw-1:0]    r_iss;
  logic [Aw:0]      r_rcv;
  logic             r_tag_scan;
  logic             r_tag_host;
  logic [Width-1:0] r_checksum;
  logic             r_pass;

  logic             w_idle;
  logic             w_start;
  logic             w_gnt;
  logic             w_scan_rsp;
  logic             w_last_iss;
  logic             w_rcv_done;

  function automatic logic [Width-1:0] f_fold(input logic [Width-1:0] c,
                                              input logic [Width-1:0] d);
    return {c[Width-2:0], c[Width-1]} ^ d;
  endfunction

  assign w_idle     = (r_state == S_IDLE);
  assign w_start    = start_i & w_idle;
  // The state register already reads IDLE while reset is held; the rst_ni
  // term keeps a pending host request from leaking onto the ROM port then.
  assign w_gnt      = host_req_i & ~start_i & w_idle & rst_ni;
  assign w_scan_rsp = rom_dvalid_i & r_tag_scan;
  assign w_last_iss = (r_iss == Aw'(Depth - 1));
  // Either every response is already counted, or the last one arrives now.
  assign w_rcv_done = (r_rcv == (Aw + 1)'(Depth)) |
                      (w_scan_rsp & (r_rcv == (Aw + 1)'(Depth - 1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i)    w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last_iss) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rcv_done) w_state_nxt = S_DONE;
      S_DONE:                  w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_iss      <= '0;
      r_rcv      <= '0;
      r_tag_scan <= 1'b0;
      r_tag_host <= 1'b0;
      r_checksum <= '0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Owner of the access issued this cycle; its data returns next cycle.
      r_tag_scan <= (r_state == S_SCAN);
      r_tag_host <= w_gnt;
      if (w_start) begin
        r_iss      <= '0;
        r_rcv      <= '0;
        r_checksum <= '0;
        r_pass     <= 1'b0;
      end else begin
        if (r_state == S_SCAN) r_iss <= r_iss + 1'b1;
        if (w_scan_rsp) begin
          r_checksum <= f_fold(r_checksum, rom_data_i);
          r_rcv      <= r_rcv + 1'b1;
        end
        if (r_state == S_DONE) r_pass <= (r_checksum == expected_i);
      end
    end
  end

  always_comb begin
    rom_cs_o   = 1'b0;
    rom_addr_o = '0;
    if (r_state == S_SCAN) begin
      rom_cs_o   = 1'b1;
      rom_addr_o = r_iss;
    end else if (w_gnt) begin
      rom_cs_o   = 1'b1;
      rom_addr_o = host_addr_i;
    end
  end

  assign host_gnt_o    = w_gnt;
  assign host_rvalid_o = rom_dvalid_i & r_tag_host;
  assign host_rdata_o  = host_rvalid_o ? rom_data_i : '0;
  assign busy_o        = (r_state == S_SCAN) | (r_state == S_DRAIN);
  assign done_o        = (r_state == S_DONE);
  assign pass_o        = r_pass;
  assign checksum_o    = r_checksum;

endmodule

// File: tb/tb_rom_scan_ctrl.sv
module tb_rom_scan_ctrl;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  expected_i = '0;
  logic          host_req_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic          host_gnt_o, host_rvalid_o;
  logic [W-1:0]  host_rdata_o;
  logic [AW-1:0] rom_addr_o;
  logic          rom_cs_o;
  logic [W-1:0]  rom_data_i = '0;
  logic          rom_dvalid_i = 1'b0;
  logic          busy_o, done_o, pass_o;
  logic [W-1:0]  checksum_o;

  rom_scan_ctrl #(.Width(W), .Depth(D), .Aw(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .expected_i(expected_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .rom_addr_o(rom_addr_o), .rom_cs_o(rom_cs_o), .rom_data_i(rom_data_i),
    .rom_dvalid_i(rom_dvalid_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .checksum_o(checksum_o)
  );

  initial forever #5 clk_i = ~clk_i;

  logic [W-1:0] mem [D];
  logic         inj = 1'b0;

  // One-cycle ROM; inj forces a stray valid to exercise post-reset filtering.
  always @(posedge clk_i) begin
    rom_dvalid_i <= rom_cs_o | inj;
    rom_data_i   <= inj ? 32'hDEAD_BEEF : mem[rom_addr_o];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference checksum: word k ends up rotated left by (Depth-1-k) positions.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
    logic [W-1:0] r = x;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  function automatic logic [W-1:0] ref_cs();
    logic [W-1:0] c = '0;
    for (int k = 0; k < D; k++) c ^= rotl(mem[k], D - 1 - k);
    return c;
  endfunction

  logic [W-1:0] q_rd[$];
  logic [W-1:0] q_cs[$];
  bit           q_pass[$];

  // Monitor: pops expectations whenever the DUT presents a result.
  bit pend = 0;
  bit pend_val = 0;
  always @(posedge clk_i) begin
    #2;
    if (!rst_ni) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("pass_o_after_done", pass_o, pend_val);
        pend = 0;
      end
      if (done_o) begin
        if (q_cs.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL done_unexpected: got done_o=1 expected no pulse at %0t", $time);
        end else begin
          chk("checksum_at_done", checksum_o, q_cs.pop_front());
          pend_val = q_pass.pop_front();
          pend = 1;
        end
      end
      if (host_rvalid_o) begin
        if (q_rd.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL rvalid_unexpected: got rvalid=1 expected 0 at %0t", $time);
        end else begin
          chk("host_rdata", host_rdata_o, q_rd.pop_front());
        end
      end else begin
        chk("host_rdata_idle", host_rdata_o, '0);
      end
    end
  end

  // Cycle-level model: m_cnt counts remaining non-idle cycles of a scan
  // (Depth SCAN cycles, one DRAIN, one DONE).
  int            m_cnt = 0;
  bit            d_start = 0;
  bit            d_req = 0;
  logic [AW-1:0] d_addr = '0;

  task automatic tick();
    bit            idle, eg, ecs;
    logic [AW-1:0] ea;
    start_i = d_start; host_req_i = d_req; host_addr_i = d_addr;
    #1;
    idle = (m_cnt == 0);
    eg   = idle & d_req & ~d_start;
    ecs  = (m_cnt >= 3) | eg;
    ea   = (m_cnt >= 3) ? AW'(D + 2 - m_cnt) : (eg ? d_addr : '0);
    chk("host_gnt", host_gnt_o, eg);
    chk("rom_cs", rom_cs_o, ecs);
    chk("rom_addr", rom_addr_o, ea);
    chk("busy", busy_o, m_cnt >= 2);
    if (eg) q_rd.push_back(mem[d_addr]);
    if (idle && d_start) begin
      q_cs.push_back(ref_cs());
      q_pass.push_back(ref_cs() == expected_i);
      m_cnt = D + 2;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
    @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_checksum"}, checksum_o, 0);
    chk({tag, "_gnt"}, host_gnt_o, 0);
    chk({tag, "_rvalid"}, host_rvalid_o, 0);
    chk({tag, "_rdata"}, host_rdata_o, 0);
    chk({tag, "_cs"}, rom_cs_o, 0);
    chk({tag, "_addr"}, rom_addr_o, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    host_req_i = 1'b1;
    #1;
    check_all_zero("reset");
    q_rd.delete(); q_cs.delete(); q_pass.delete();
    m_cnt = 0;
    host_req_i = 1'b0;
    @(negedge clk_i);
    inj = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_reset_rvalid", host_rvalid_o, 0);
    inj = 1'b0;
    @(negedge clk_i);
    chk("post_reset_checksum", checksum_o, 0);
  endtask

  task automatic fill_inc();
    for (int k = 0; k < D; k++) mem[k] = W'(k + 1);
  endtask

  task automatic run_scan(input logic [W-1:0] exp, input logic [W-1:0] want_cs, input bit want_pass);
    expected_i = exp;
    d_start = 1; tick(); d_start = 0;
    while (m_cnt != 0) tick();
    chk("scan_checksum", checksum_o, want_cs);
    chk("scan_pass", pass_o, want_pass);
  endtask

  initial begin
    fill_inc();
    repeat (2) @(negedge clk_i);
    check_all_zero("in_reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Matching and mismatching reference values.
    run_scan(32'd2, 32'd2, 1'b1);
    tick();
    run_scan(32'd5, 32'd2, 1'b0);
    tick();

    // Host request held through a scan is granted on the first idle cycle.
    expected_i = 32'd2;
    d_start = 1; tick(); d_start = 0;
    d_req = 1; d_addr = 2'd3;
    while (m_cnt != 0) tick();
    tick();
    d_req = 0;
    tick();
    chk("host_read_keeps_checksum", checksum_o, 32'd2);

    // start_i and host_req_i together: start wins, host waits.
    d_start = 1; d_req = 1; d_addr = 2'd1; tick(); d_start = 0;
    while (m_cnt != 0) tick();
    tick();
    d_req = 0;
    tick();

    // Back-to-back host reads.
    for (int a = 0; a < D; a++) begin d_req = 1; d_addr = AW'(a); tick(); end
    d_req = 0; tick(); tick();

    // Reset in the middle of a scan, then a clean scan.
    d_start = 1; tick(); d_start = 0;
    tick(); tick(); tick();
    do_reset();
    run_scan(32'd2, 32'd2, 1'b1);
    tick();

    // start_i pulsed while scanning is ignored.
    expected_i = 32'd2;
    d_start = 1; tick();
    d_start = 0; tick();
    d_start = 1; tick();
    d_start = 0; tick();
    d_start = 1; tick();
    d_start = 0;
    while (m_cnt != 0) tick();
    tick(); tick();

    // Randomized traffic with fresh ROM contents per scan.
    for (int c = 0; c < 600; c++) begin
      if (m_cnt == 0 && $urandom_range(0, 5) == 0) begin
        for (int k = 0; k < D; k++) mem[k] = $urandom;
        expected_i = ($urandom_range(0, 1) == 1) ? ref_cs() : $urandom;
        d_start = 1;
      end else begin
        d_start = ($urandom_range(0, 15) == 0);
      end
      d_req  = ($urandom_range(0, 2) == 0);
      d_addr = AW'($urandom_range(0, D - 1));
      tick();
    end
    d_start = 0; d_req = 0;
    repeat (12) tick();
    chk("leftover_reads", q_rd.size(), 0);
    chk("leftover_scans", q_cs.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
